// File: rtl/msg_ram_sequencer.sv
// Message RAM transmit sequencer: streams bytes from a synchronous RAM to a valid/ready sink.
// Optional trailing XOR checksum beat is enabled by defining CHECKSUM_EN.
module msg_ram_sequencer #(
    parameter int         ADDR_W    = 8,
    parameter int         MAX_LEN   = 256,
    parameter logic [7:0] TERM_CHAR = 8'h00
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              ram_rd,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [7:0]        ram_rdata,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   byte_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_PRESENT,
        S_CHK,
        S_DONE
    } state_t;

    localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W + 1)'(MAX_LEN);

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] addr_next;
    logic [ADDR_W:0]   cnt_next;

    assign ram_addr  = addr;
    assign addr_next = addr + ADDR_W'(1);
    assign cnt_next  = byte_count + (ADDR_W + 1)'(1);

`ifdef CHECKSUM_EN
    logic [7:0] checksum;
    logic [7:0] chk_next;

    assign chk_next = checksum ^ out_data;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            addr       <= '0;
            byte_count <= '0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            ram_rd     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
`ifdef CHECKSUM_EN
            checksum   <= '0;
`endif
        end else begin
            ram_rd <= 1'b0;
            done   <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        addr       <= base_addr;
                        byte_count <= '0;
`ifdef CHECKSUM_EN
                        checksum   <= '0;
`endif
                        ram_rd     <= 1'b1;
                        busy       <= 1'b1;
                        state      <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (ram_rdata == TERM_CHAR) begin
`ifdef CHECKSUM_EN
                        out_data  <= checksum;
                        out_valid <= 1'b1;
                        state     <= S_CHK;
`else
                        done  <= 1'b1;
                        state <= S_DONE;
`endif
                    end else begin
                        out_data  <= ram_rdata;
                        out_valid <= 1'b1;
                        state     <= S_PRESENT;
                    end
                end
                S_PRESENT: begin
                    if (out_ready) begin
                        byte_count <= cnt_next;
                        addr       <= addr_next;
`ifdef CHECKSUM_EN
                        checksum   <= chk_next;
`endif
                        // Length cap reached: no further read is issued.
                        if (cnt_next == MAX_CNT) begin
`ifdef CHECKSUM_EN
                            out_data <= chk_next;
                            state    <= S_CHK;
`else
                            out_valid <= 1'b0;
                            done      <= 1'b1;
                            state     <= S_DONE;
`endif
                        end else begin
                            out_valid <= 1'b0;
                            ram_rd    <= 1'b1;
                            state     <= S_FETCH;
                        end
                    end
                end
                S_CHK: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        done      <= 1'b1;
                        state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
            // Abort wins over the state update but keeps any beat accepted this cycle.
            if (abort && state != S_IDLE) begin
                state     <= S_IDLE;
                out_valid <= 1'b0;
                ram_rd    <= 1'b0;
                done      <= 1'b0;
                busy      <= 1'b0;
            end
        end
    end

endmodule
